video_timing_gen: RTL and testbench

//  Parametrised video timing generator and pixel source for the video_if master side.

---
 rtl/video_timing_pkg.sv | 38 +++
 rtl/video_pattern_gen.sv | 34 +++
 rtl/video_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared types, bar colours and frame-size helpers for the video timing generator
package video_timing_pkg;

  typedef enum logic [1:0] {
    PAT_STREAM = 2'd0,
    PAT_BARS   = 2'd1,
    PAT_CHECK  = 2'd2,
    PAT_SOLID  = 2'd3
  } pattern_e;

  typedef logic [23:0] rgb_t;

  localparam rgb_t RGB_BLACK = 24'h000000;
  localparam rgb_t RGB_WHITE = 24'hFFFFFF;
  localparam rgb_t RGB_BLUE  = 24'h0000FF;

  function automatic rgb_t bar_colour(input logic [31:0] idx);
    case (idx)
      32'd0:   return 24'hFFFFFF;
      32'd1:   return 24'hFFFF00;
      32'd2:   return 24'h00FFFF;
      32'd3:   return 24'h00FF00;
      32'd4:   return 24'hFF00FF;
      32'd5:   return 24'hFF0000;
      32'd6:   return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic int htotal(input int disp, input int fp, input int pulse, input int bp);
    return disp + fp + pulse + bp;
  endfunction

  function automatic int vtotal(input int disp, input int fp, input int pulse, input int bp);
    return disp + fp + pulse + bp;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - combinational test-pattern colour for a given mode and pixel position
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic [1:0]    mode,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [23:0]   rgb
);

  logic [31:0] x_w;
  logic [31:0] y_w;
  logic [31:0] bar_idx;
  logic [31:0] chk;

  always_comb begin
    x_w     = 32'(x);
    y_w     = 32'(y);
    bar_idx = (x_w * 32'd8) / 32'(HDISP);
    chk     = ((x_w >> 3) ^ (y_w >> 3)) & 32'd1;
    rgb     = RGB_BLACK;
    case (pattern_e'(mode))
      PAT_BARS:  rgb = bar_colour(bar_idx);
      PAT_CHECK: rgb = (chk != 32'd0) ? RGB_WHITE : RGB_BLACK;
      PAT_SOLID: rgb = RGB_BLUE;
      default:   rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - h/v timing counters, sync decode, FIFO pixel stream with underflow tracking
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   HDISP  = 800,
  parameter int   VDISP  = 480,
  parameter int   HFP    = 40,
  parameter int   HPULSE = 48,
  parameter int   HBP    = 40,
  parameter int   VFP    = 13,
  parameter int   VPULSE = 3,
  parameter int   VBP    = 29,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst_n,
  input  logic                     enable,
  input  logic [1:0]               pattern_sel,
  input  logic [23:0]              fifo_rdata,
  input  logic                     fifo_empty,
  output logic                     fifo_rd,
  output logic                     video_HS,
  output logic                     video_VS,
  output logic                     video_BLANK,
  output logic [23:0]              video_RGB,
  output logic [$clog2(HDISP)-1:0] pix_x,
  output logic [$clog2(VDISP)-1:0] pix_y,
  output logic                     frame_start,
  output logic                     underflow,
  output logic [15:0]              underflow_cnt
);

  localparam int HTOTAL = htotal(HDISP, HFP, HPULSE, HBP);
  localparam int VTOTAL = vtotal(VDISP, VFP, VPULSE, VBP);
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);

  localparam logic [HW-1:0] H_DISP   = HW'(HDISP);
  localparam logic [HW-1:0] H_SYNC_S = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HDISP + HFP + HPULSE);
  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_DISP   = VW'(VDISP);
  localparam logic [VW-1:0] V_SYNC_S = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VDISP + VFP + VPULSE);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  pattern_e      mode_q, mode_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic          uf_q, uf_d;
  logic [15:0]   uf_cnt_q, uf_cnt_d;

  logic          at_origin, active, stream;
  pattern_e      mode_eff;
  logic [23:0]   pat_rgb;

  // The pattern chosen at (0,0) already applies to that first pixel, so a switch is frame-exact.
  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign mode_eff  = at_origin ? pattern_e'(pattern_sel) : mode_q;
  assign active    = (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);
  assign stream    = (mode_eff == PAT_STREAM);
  assign fifo_rd   = enable && active && stream && !fifo_empty;

  video_pattern_gen #(
    .HDISP (HDISP),
    .XW    (XW),
    .YW    (YW)
  ) u_pattern (
    .mode  (mode_eff),
    .x     (h_cnt_q[XW-1:0]),
    .y     (v_cnt_q[YW-1:0]),
    .rgb   (pat_rgb)
  );

  always_comb begin
    h_cnt_d  = '0;
    v_cnt_d  = '0;
    mode_d   = mode_q;
    hs_d     = ~HS_POL;
    vs_d     = ~VS_POL;
    blank_d  = 1'b0;
    rgb_d    = '0;
    pix_x_d  = '0;
    pix_y_d  = '0;
    fs_d     = 1'b0;
    uf_d     = uf_q;
    uf_cnt_d = uf_cnt_q;
    if (enable) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
      end
      mode_d  = mode_eff;
      hs_d    = (h_cnt_q >= H_SYNC_S && h_cnt_q < H_SYNC_E) ? HS_POL : ~HS_POL;
      vs_d    = (v_cnt_q >= V_SYNC_S && v_cnt_q < V_SYNC_E) ? VS_POL : ~VS_POL;
      blank_d = active;
      fs_d    = at_origin;
      pix_x_d = active ? h_cnt_q[XW-1:0] : pix_x_q;
      pix_y_d = active ? v_cnt_q[YW-1:0] : pix_y_q;
      if (active) begin
        if (!stream) begin
          rgb_d = pat_rgb;
        end else if (!fifo_empty) begin
          rgb_d = fifo_rdata;
        end else begin
          uf_d = 1'b1;
          if (uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      mode_q   <= PAT_STREAM;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      blank_q  <= 1'b0;
      rgb_q    <= '0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      fs_q     <= 1'b0;
      uf_q     <= 1'b0;
      uf_cnt_q <= '0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      mode_q   <= mode_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      rgb_q    <= rgb_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      fs_q     <= fs_d;
      uf_q     <= uf_d;
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign video_HS      = hs_q;
  assign video_VS      = vs_q;
  assign video_BLANK   = blank_q;
  assign video_RGB     = rgb_q;
  assign pix_x         = pix_x_q;
  assign pix_y         = pix_y_q;
  assign frame_start   = fs_q;
  assign underflow     = uf_q;
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a 14x7 total / 8x4 active screen
module tb_video_timing_gen;

  localparam int HDISP = 8, VDISP = 4, HFP = 2, HPULSE = 2, HBP = 2;
  localparam int VFP = 1, VPULSE = 1, VBP = 1;
  localparam int HTOTAL = 14, VTOTAL = 7, FRAME = 98;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  sel = 2'd3;
  logic [23:0] rdata = 24'h0;
  logic        empty = 1'b0;
  logic        fifo_rd, video_HS, video_VS, video_BLANK, frame_start, underflow;
  logic [23:0] video_RGB;
  logic [2:0]  pix_x;
  logic [1:0]  pix_y;
  logic [15:0] underflow_cnt;

  video_timing_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(en), .pattern_sel(sel),
    .fifo_rdata(rdata), .fifo_empty(empty), .fifo_rd(fifo_rd),
    .video_HS(video_HS), .video_VS(video_VS), .video_BLANK(video_BLANK),
    .video_RGB(video_RGB), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs, vs, blank;
    logic [23:0] rgb;
    logic [2:0]  px;
    logic [1:0]  py;
    logic        fs, uf;
    logic [15:0] ucnt;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, last_fs = -1, fs_period = 0;
  int blank_n, vs_n, hs_n, rd_n;
  int m_h = 0, m_v = 0, m_mode = 0, m_px = 0, m_py = 0, m_ucnt = 0;
  logic m_uf = 1'b0;
  logic [23:0] data_q = 24'h100000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  function automatic logic [23:0] pat_rgb(input int mode, input int x, input int y);
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (mode)
      1:       return bars[(x * 8) / HDISP];
      2:       return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_mode = 0; m_px = 0; m_py = 0; m_uf = 1'b0; m_ucnt = 0;
  endtask

  // One pixel clock: drive at negedge, predict, then compare the registered outputs after posedge.
  task automatic step(input logic e, input logic [1:0] s, input logic emp);
    exp_t x;
    logic act, st, exp_rd, rd_seen;
    int me;
    @(negedge clk);
    en = e; sel = s; empty = emp; rdata = data_q;
    #1;
    x = '0; x.hs = 1'b1; x.vs = 1'b1; exp_rd = 1'b0;
    if (!e) begin
      m_h = 0; m_v = 0; m_px = 0; m_py = 0;
    end else begin
      me = (m_h == 0 && m_v == 0) ? int'(s) : m_mode;
      m_mode = me;
      act = (m_h < HDISP) && (m_v < VDISP);
      st = (me == 0);
      exp_rd = act && st && !emp;
      x.hs = !(m_h >= HDISP + HFP && m_h < HDISP + HFP + HPULSE);
      x.vs = !(m_v >= VDISP + VFP && m_v < VDISP + VFP + VPULSE);
      x.blank = act;
      x.fs = (m_h == 0 && m_v == 0);
      if (act) begin
        x.rgb = st ? (emp ? 24'h0 : rdata) : pat_rgb(me, m_h, m_v);
        m_px = m_h; m_py = m_v;
        if (st && emp) begin
          m_uf = 1'b1;
          if (m_ucnt < 65535) m_ucnt++;
        end
      end
      m_h++;
      if (m_h == HTOTAL) begin
        m_h = 0;
        m_v = (m_v == VTOTAL - 1) ? 0 : m_v + 1;
      end
    end
    x.px = 3'(m_px); x.py = 2'(m_py); x.uf = m_uf; x.ucnt = 16'(m_ucnt);
    check("fifo_rd", fifo_rd, exp_rd);
    rd_seen = fifo_rd;
    sb.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
    if (rd_seen) begin data_q++; rd_n++; end
    if (sb.size() == 0) check("sb_underrun", 1, 0);
    else begin
      x = sb.pop_front();
      check("hs", video_HS, x.hs);
      check("vs", video_VS, x.vs);
      check("blank", video_BLANK, x.blank);
      check("rgb", video_RGB, x.rgb);
      check("pix_x", pix_x, x.px);
      check("pix_y", pix_y, x.py);
      check("frame_start", frame_start, x.fs);
      check("underflow", underflow, x.uf);
      check("underflow_cnt", underflow_cnt, x.ucnt);
    end
    if (video_BLANK) blank_n++;
    if (!video_VS) vs_n++;
    if (!video_HS) hs_n++;
    if (frame_start) begin
      if (last_fs >= 0) fs_period = cyc - last_fs;
      last_fs = cyc;
    end
  endtask

  task automatic run_frame(input logic [1:0] s, input logic uf_test);
    blank_n = 0; vs_n = 0; hs_n = 0; rd_n = 0;
    for (int i = 0; i < FRAME; i++)
      step(1'b1, s, uf_test && m_v == 0 && (m_h == 3 || m_h == 4));
  endtask

  task automatic sync_frame(input logic [1:0] s);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_h == 0 && m_v == 0) return;
      step(1'b1, s, 1'b0);
    end
    check("sync_frame_timeout", 0, 1);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_hs", video_HS, 1);
    check("rst_vs", video_VS, 1);
    check("rst_blank", video_BLANK, 0);
    check("rst_rgb", video_RGB, 0);
    check("rst_fs", frame_start, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Solid blue: frame period, per-frame blank/HS/VS occupancy.
    step(1'b1, 2'd3, 1'b0);
    check("first_fs", frame_start, 1);
    run_frame(2'd3, 1'b0);
    check("fs_period", fs_period, FRAME);
    check("blank_per_frame", blank_n, 32);
    check("hs_low_per_frame", hs_n, 14);
    check("vs_low_per_frame", vs_n, 14);
    check("rd_in_pattern", rd_n, 0);

    // Stream with a permanently full FIFO.
    sync_frame(2'd0);
    run_frame(2'd0, 1'b0);
    check("rd_per_frame", rd_n, 32);
    check("no_underflow", underflow, 0);

    // Stream with an empty FIFO at x=3..4 of line 0.
    run_frame(2'd0, 1'b1);
    check("uf_rd_per_frame", rd_n, 30);
    check("uf_flag", underflow, 1);
    check("uf_cnt", underflow_cnt, 2);

    // Bars, switched to checker mid-frame.
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, (i < 40) ? 2'd1 : 2'd2, 1'b0);
      if (i == 0) check("bar_x0_white", video_RGB, 24'hFFFFFF);
      if (i == 1) check("bar_x1_yellow", video_RGB, 24'hFFFF00);
      if (i == 6) check("bar_x6_blue", video_RGB, 24'h0000FF);
      if (i == 45) check("bar_persists", video_RGB, 24'h00FF00);
    end
    step(1'b1, 2'd2, 1'b0);
    check("checker_fs", frame_start, 1);
    check("checker_x0", video_RGB, 24'h000000);

    // Asynchronous reset with HS asserted.
    for (int i = 0; i < 2 * HTOTAL; i++) begin
      step(1'b1, 2'd3, 1'b0);
      if (!video_HS) break;
    end
    check("hs_before_rst", video_HS, 0);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("arst_hs", video_HS, 1);
    check("arst_vs", video_VS, 1);
    check("arst_blank", video_BLANK, 0);
    check("arst_rgb", video_RGB, 0);
    check("arst_uf_cnt", underflow_cnt, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd3, 1'b0);
    check("post_rst_fs", frame_start, 1);

    // Enable dropped for 20 cycles mid-frame, stream selected so a stray pop would show.
    for (int i = 0; i < 30; i++) step(1'b1, 2'd3, 1'b0);
    rd_n = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 2'd0, 1'b0);
    check("idle_rd", rd_n, 0);
    check("idle_blank", video_BLANK, 0);
    step(1'b1, 2'd3, 1'b0);
    check("reenable_fs", frame_start, 1);
    check("reenable_x", pix_x, 0);
    check("reenable_rgb", video_RGB, 24'h0000FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
